// File: rtl/coffee_pkg.sv
// Shared types for the coffee maker sequencer: state encoding and the
// actuator vector layout used to decode outputs from state.
package coffee_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        MW_IN  = 3'd1,
        MW_OUT = 3'd2,
        E_IN   = 3'd3,
        E_OUT  = 3'd4,
        C_IN   = 3'd5,
        C_OUT  = 3'd6,
        DONE   = 3'd7
    } state_t;

    localparam int ACT_W  = 7;
    localparam int P_BIT  = 6;
    localparam int M_BIT  = 5;
    localparam int W_BIT  = 4;
    localparam int C_BIT  = 3;
    localparam int S_BIT  = 2;
    localparam int ST_BIT = 1;
    localparam int F_BIT  = 0;

    // Moore decode: the actuator set each state drives.
    function automatic logic [ACT_W-1:0] act_for(input state_t s);
        logic [ACT_W-1:0] a;
        a = '0;
        case (s)
            MW_IN:  begin a[P_BIT] = 1'b1; a[M_BIT] = 1'b1; a[W_BIT] = 1'b1; end
            MW_OUT: begin a[P_BIT] = 1'b1; end
            E_IN:   begin a[P_BIT] = 1'b1; a[C_BIT] = 1'b1; a[S_BIT] = 1'b1; end
            E_OUT:  begin a[P_BIT] = 1'b1; a[ST_BIT] = 1'b1; end
            C_IN:   begin a[P_BIT] = 1'b1; a[W_BIT] = 1'b1; end
            C_OUT:  begin a[P_BIT] = 1'b1; a[ST_BIT] = 1'b1; end
            DONE:   begin a[F_BIT] = 1'b1; end
            default: a = '0;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/coffee_making.sv
// Coffee maker sequencer: walks the fill/dose/serve stages on sensor
// handshakes, with a per-stage watchdog that aborts a stalled brew to IDLE.
module coffee_making
    import coffee_pkg::*;
#(
    parameter int unsigned STAGE_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic mwis,
    input  logic mwos,
    input  logic ewis,
    input  logic ewos,
    input  logic cwis,
    input  logic cwos,
    output logic p,
    output logic m,
    output logic w,
    output logic c,
    output logic s,
    output logic st,
    output logic f
);

    localparam int CW     = (STAGE_TIMEOUT > 0) ? $clog2(STAGE_TIMEOUT + 1) : 1;
    localparam int LAST_I = (STAGE_TIMEOUT > 0) ? int'(STAGE_TIMEOUT) - 1 : 0;
    localparam logic [CW-1:0] LAST    = LAST_I[CW-1:0];
    localparam logic [CW-1:0] CNT_MAX = '1;

    state_t            state_reg, state_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic              wait_st;
    logic              exit_hit;
    logic              timeout_hit;
    logic [ACT_W-1:0]  act;

    // The final cycle of a stall is the one whose count equals TIMEOUT-1,
    // so a wait state is held for exactly STAGE_TIMEOUT cycles.
    generate
        if (STAGE_TIMEOUT == 0) begin : g_no_wdog
            assign timeout_hit = 1'b0;
        end else begin : g_wdog
            assign timeout_hit = (cnt_reg == LAST);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        wait_st    = 1'b1;
        exit_hit   = 1'b0;
        case (state_reg)
            IDLE:   begin wait_st = 1'b0; if (start) state_next = MW_IN; end
            MW_IN:  begin exit_hit = mwis; if (mwis) state_next = MW_OUT; end
            MW_OUT: begin exit_hit = mwos; if (mwos) state_next = E_IN;   end
            E_IN:   begin exit_hit = ewis; if (ewis) state_next = E_OUT;  end
            E_OUT:  begin exit_hit = ewos; if (ewos) state_next = C_IN;   end
            C_IN:   begin exit_hit = cwis; if (cwis) state_next = C_OUT;  end
            C_OUT:  begin exit_hit = cwos; if (cwos) state_next = DONE;   end
            DONE:   begin wait_st = 1'b0; state_next = IDLE; end
            default: begin wait_st = 1'b0; state_next = IDLE; end
        endcase

        if (wait_st && !exit_hit && timeout_hit)
            state_next = IDLE;

        cnt_next = cnt_reg;
        if (state_next != state_reg)
            cnt_next = '0;
        else if (wait_st && cnt_reg != CNT_MAX)
            cnt_next = cnt_reg + 1'b1;

        act = act_for(state_reg);
    end

    assign p  = act[P_BIT];
    assign m  = act[M_BIT];
    assign w  = act[W_BIT];
    assign c  = act[C_BIT];
    assign s  = act[S_BIT];
    assign st = act[ST_BIT];
    assign f  = act[F_BIT];

endmodule

// File: tb/tb_coffee_making.sv
// Directed bench for coffee_making: a stage-index model checked every cycle
// against two instances (default watchdog and a 4-cycle watchdog).
module tb_coffee_making;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [5:0] sens;   // {cwos, cwis, ewos, ewis, mwos, mwis}

    logic p0, m0, w0, c0, s0, st0, f0;
    logic p1, m1, w1, c1, s1, st1, f1;
    logic [6:0] o0, o1;

    int n_tests = 0;
    int n_fail  = 0;
    int f_cnt0  = 0;
    int f_cnt1  = 0;

    always #5 clk = ~clk;

    coffee_making #(.STAGE_TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .start(start),
        .mwis(sens[0]), .mwos(sens[1]), .ewis(sens[2]),
        .ewos(sens[3]), .cwis(sens[4]), .cwos(sens[5]),
        .p(p0), .m(m0), .w(w0), .c(c0), .s(s0), .st(st0), .f(f0)
    );

    coffee_making #(.STAGE_TIMEOUT(4)) dut_wd (
        .clk(clk), .rst(rst), .start(start),
        .mwis(sens[0]), .mwos(sens[1]), .ewis(sens[2]),
        .ewos(sens[3]), .cwis(sens[4]), .cwos(sens[5]),
        .p(p1), .m(m1), .w(w1), .c(c1), .s(s1), .st(st1), .f(f1)
    );

    assign o0 = {p0, m0, w0, c0, s0, st0, f0};
    assign o1 = {p1, m1, w1, c1, s1, st1, f1};

    // Model: stage 0 idle, 1..6 wait stages (stage k waits on sens[k-1]),
    // 7 done. dwell counts completed cycles in the current wait stage.
    int         tmo[2] = '{255, 4};
    int         stg[2];
    int         dwell[2];
    logic [6:0] exp_tab[8] = '{7'b0000000, 7'b1110000, 7'b1000000, 7'b1001100,
                               7'b1000010, 7'b1010000, 7'b1000010, 7'b0000001};

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                stg[k]   <= 0;
                dwell[k] <= 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (stg[k] == 0) begin
                    if (start) begin stg[k] <= 1; dwell[k] <= 0; end
                end else if (stg[k] == 7) begin
                    stg[k] <= 0;
                end else if (sens[stg[k]-1]) begin
                    stg[k]   <= stg[k] + 1;
                    dwell[k] <= 0;
                end else if (tmo[k] != 0 && dwell[k] + 1 >= tmo[k]) begin
                    stg[k]   <= 0;
                    dwell[k] <= 0;
                end else begin
                    dwell[k] <= dwell[k] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        n_tests += 2;
        if (o0 !== exp_tab[stg[0]]) begin
            n_fail++;
            $display("FAIL cycle_cmp dut t=%0t got=%b exp=%b", $time, o0, exp_tab[stg[0]]);
        end
        if (o1 !== exp_tab[stg[1]]) begin
            n_fail++;
            $display("FAIL cycle_cmp dut_wd t=%0t got=%b exp=%b", $time, o1, exp_tab[stg[1]]);
        end
        if (f0) f_cnt0++;
        if (f1) f_cnt1++;
    end

    task automatic chk(input string nm, input logic [6:0] got, input logic [6:0] exp_v);
        n_tests++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%b exp=%b", nm, $time, got, exp_v);
        end else begin
            $display("[TB] ok %s t=%0t out=%b", nm, $time, got);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int exp_v);
        n_tests++;
        if (got != exp_v) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp_v);
        end else begin
            $display("[TB] ok %s value=%0d", nm, got);
        end
    endtask

    task automatic cyc(input logic [5:0] sv, input logic st_i);
        @(negedge clk);
        sens  = sv;
        start = st_i;
        @(posedge clk);
        #1;
    endtask

    logic [6:0] nom_exp[7] = '{7'b1000000, 7'b1001100, 7'b1000010, 7'b1010000,
                               7'b1000010, 7'b0000001, 7'b0000000};
    logic [6:0] hold_exp[6] = '{7'b1110000, 7'b1000000, 7'b1001100,
                                7'b1000010, 7'b1010000, 7'b1000010};

    initial begin
        int fb0, fb1;
        rst = 1'b0; start = 1'b1; sens = '0;
        #1;
        chk("reset_async_dut", o0, 7'b0);
        chk("reset_async_wd", o1, 7'b0);
        cyc(6'd0, 1'b1); chk("reset_hold_dut", o0, 7'b0);
        cyc(6'd0, 1'b1); chk("reset_hold_wd", o1, 7'b0);
        @(negedge clk); rst = 1'b1; start = 1'b0;
        cyc(6'd0, 1'b0); chk("idle_after_reset", o0, 7'b0);

        // Nominal brew
        cyc(6'd0, 1'b1); chk("nom_mw_in", o0, 7'b1110000);
        for (int i = 0; i < 6; i++) begin
            cyc(6'(1 << i), 1'b0);
            chk($sformatf("nom_step%0d", i), o0, nom_exp[i]);
        end
        cyc(6'd0, 1'b0); chk("nom_idle", o0, nom_exp[6]);

        // Out-of-order sensors in MW_IN
        cyc(6'd0, 1'b1); chk("ooo_mw_in", o0, 7'b1110000);
        cyc(6'b100100, 1'b0); chk("ooo_ignored", o0, 7'b1110000);
        cyc(6'b000001, 1'b0); chk("ooo_mw_out", o0, 7'b1000000);
        for (int i = 1; i < 6; i++) cyc(6'(1 << i), 1'b0);
        cyc(6'd0, 1'b0); chk("ooo_idle", o0, 7'b0);

        // Stall 10 cycles per stage
        fb0 = f_cnt0; fb1 = f_cnt1;
        cyc(6'd0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            repeat (10) cyc(6'd0, 1'b0);
            chk($sformatf("stall_hold%0d", i), o0, hold_exp[i]);
            cyc(6'(1 << i), 1'b0);
        end
        cyc(6'd0, 1'b0);
        chk_int("stall_f_once", f_cnt0 - fb0, 1);
        chk_int("stall_wd_aborted_no_f", f_cnt1 - fb1, 0);

        // Watchdog with STAGE_TIMEOUT=4
        fb1 = f_cnt1;
        cyc(6'd0, 1'b1); chk("wd_mw_in", o1, 7'b1110000);
        start = 1'b0;
        repeat (3) cyc(6'd0, 1'b0);
        chk("wd_still_mw_in", o1, 7'b1110000);
        cyc(6'd0, 1'b0); chk("wd_abort", o1, 7'b0);
        chk("wd_dut255_waiting", o0, 7'b1110000);
        cyc(6'd0, 1'b0); chk("wd_idle", o1, 7'b0);
        cyc(6'd0, 1'b1); chk("wd_restart", o1, 7'b1110000);
        chk_int("wd_no_f", f_cnt1 - fb1, 0);

        // Reset mid-brew, asserted mid-clock
        #2; rst = 1'b0; start = 1'b1;
        #1;
        chk("midrst_async_dut", o0, 7'b0);
        chk("midrst_async_wd", o1, 7'b0);
        cyc(6'd0, 1'b1); chk("midrst_hold", o0, 7'b0);
        @(negedge clk); rst = 1'b1; start = 1'b0;
        cyc(6'd0, 1'b0); chk("midrst_idle", o0, 7'b0);

        // Back-to-back with start held
        cyc(6'd0, 1'b1); chk("b2b_mw_in", o0, 7'b1110000);
        for (int i = 0; i < 6; i++) cyc(6'(1 << i), 1'b1);
        chk("b2b_done", o0, 7'b0000001);
        cyc(6'd0, 1'b1); chk("b2b_idle", o0, 7'b0);
        cyc(6'd0, 1'b1); chk("b2b_mw_in_again", o0, 7'b1110000);
        chk("b2b_wd_mw_in_again", o1, 7'b1110000);
        cyc(6'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/coffee_making.md
Name: coffee_making

Overview:
- Moore FSM sequencer for a drip/mix coffee maker, sitting between the front-panel start button, the process-stage level sensors and the actuator drivers.
- On start it runs three in/out stages in fixed order:
  - milk/water fill and transfer
  - coffee/sugar dose and blend
  - cup fill and serve
- It drives one actuator set per state, then pulses finished and returns to idle.

Parameters:
- STAGE_TIMEOUT, default 255: max cycles any wait state may remain before abort to IDLE; 0 disables the watchdog.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset (rst=0 resets).
- start  input  1  brew request, level-sensitive, sampled only in IDLE.
- mwis  input  1  milk/water inlet level reached.
- mwos  input  1  milk/water transfer-out complete.
- ewis  input  1  coffee/sugar dose-in complete.
- ewos  input  1  blend/extract-out complete.
- cwis  input  1  cup fill-in complete.
- cwos  input  1  cup serve-out complete.
- p  output  1  power/process active.
- m  output  1  milk valve.
- w  output  1  water valve/heater.
- c  output  1  coffee powder feeder.
- s  output  1  sugar feeder.
- st  output  1  stirrer motor.
- f  output  1  finished indicator.

Behaviour:
- All inputs sampled on rising clk. Outputs are decoded combinationally from the registered state only (Moore); no input-to-output paths.
- Async reset (rst=0): state=IDLE, watchdog counter=0, all outputs 0 immediately, independent of clk.
- States, outputs and exits (outputs not listed are 0):
  - IDLE: no outputs. start=1 -> MW_IN.
  - MW_IN: p,m,w=1. mwis=1 -> MW_OUT.
  - MW_OUT: p=1. mwos=1 -> E_IN.
  - E_IN: p,c,s=1. ewis=1 -> E_OUT.
  - E_OUT: p,st=1. ewos=1 -> C_IN.
  - C_IN: p,w=1. cwis=1 -> C_OUT.
  - C_OUT: p,st=1. cwos=1 -> DONE.
  - DONE: f=1 for exactly one cycle, then IDLE unconditionally.
- Latency: one cycle per transition. With each sensor asserted for one cycle in order, start at edge N gives f=1 during cycle N+7.
- Each wait state responds only to its own sensor; all other sensors are ignored. Several sensors high at once -> only the current state's sensor counts, and only one state advance per cycle.
- start is ignored outside IDLE. If start is still high in DONE, the next brew begins one cycle after DONE (DONE -> IDLE -> MW_IN).
- Watchdog:
  - Counter clears on every state change and counts cycles spent in a wait state.
  - When it reaches STAGE_TIMEOUT with the exit sensor still low -> IDLE with all outputs 0 and no f pulse.
  - Counter width is clog2(STAGE_TIMEOUT+1) and it saturates.
- Reset mid-brew aborts immediately to IDLE. Unused state encodings recover to IDLE.

Decomposition:
- Shared package coffee_pkg:
  - state enum (IDLE, MW_IN, MW_OUT, E_IN, E_OUT, C_IN, C_OUT, DONE; 3-bit binary)
  - actuator bit-position constants
- No sub-module is needed. The watchdog counter stays inline.

Test Plan:
- Reset: rst=0 mid-clock with start=1 -> all outputs 0 asynchronously; state stays IDLE while rst=0.
- Nominal brew: start=1, then one-cycle pulses mwis, mwos, ewis, ewos, cwis, cwos on successive edges -> output sequence:
  - (p,m,w)
  - (p)
  - (p,c,s)
  - (p,st)
  - (p,w)
  - (p,st)
  - f one cycle
  - then all 0.
- Out-of-order sensors: in MW_IN assert cwos and ewis -> state unchanged and outputs stay p,m,w; then mwis -> MW_OUT.
- Stall: hold each sensor off for 10 cycles per stage -> outputs hold steady; full sequence completes with f=1 once.
- Watchdog: STAGE_TIMEOUT=4, start, never assert mwis -> after 4 cycles in MW_IN outputs go to 0, f never asserted, start reaccepted.
- Back-to-back: keep start=1 through DONE -> MW_IN re-entered two cycles after f rises.
